// File: rtl/play_status_pkg.sv
// Shared definitions for the play_status transport and elapsed-time tracker.
// Holds the state encodings, the time constants and the BCD helper.
package play_status_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    // 99:59 is the largest time the mm:ss display can show.
    localparam int SEC_MAX          = 5999;
    localparam int PREV_RESTART_SEC = 3;

    // Values 0..99 give two BCD digits.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/play_status_bin2bcd8.sv
// Combinational 7-bit binary to two-digit BCD converter (inputs 0..99).
module play_status_bin2bcd8
    import play_status_pkg::*;
(
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    assign bcd = to_bcd(bin);

endmodule

// File: rtl/play_status.sv
// Transport state machine, elapsed-seconds counter, track and volume tracking.
// Every output is registered; DISP is built from next-state values.
module play_status
    import play_status_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TRACKS   = 8,
    parameter int VOL_MAX  = 15,
    parameter int VOL_INIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PLAY_PAUSE,
    input  logic        STOP,
    input  logic        NEXT,
    input  logic        PREV,
    input  logic        VOL_UP,
    input  logic        VOL_DN,
    input  logic        SONG_END,
    output logic [31:0] DISP,
    output logic        PLAYING,
    output logic [6:0]  TRACK,
    output logic [6:0]  VOLUME,
    output logic        TRACK_CHG
);

    localparam int             PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_LAST   = PW'(CLK_HZ - 1);
    localparam logic [6:0]     TRACK_LAST   = 7'(TRACKS - 1);
    localparam logic [6:0]     VOL_TOP      = 7'(VOL_MAX);
    localparam logic [6:0]     VOL_RST      = 7'(VOL_INIT);
    localparam logic [7:0]     VOL_INIT_BCD = to_bcd(7'(VOL_INIT));
    localparam logic [15:0]    SEC_SAT      = 16'(SEC_MAX);
    localparam logic [15:0]    SEC_RESTART  = 16'(PREV_RESTART_SEC);

    state_t          state, state_n;
    logic [PW-1:0]   presc, presc_n;
    logic [15:0]     seconds, seconds_n;
    logic [6:0]      track, track_n;
    logic [6:0]      volume, volume_n;
    logic            chg_n;
    logic [7:0]      track_bcd, volume_bcd;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_n   = state;
        presc_n   = presc;
        seconds_n = seconds;
        track_n   = track;
        chg_n     = 1'b0;

        if (state == ST_PLAYING) begin
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                if (seconds != SEC_SAT) seconds_n = seconds + 16'd1;
            end else begin
                presc_n = presc + PW'(1);
            end
        end

        // Only the highest-priority transport event acts; an ignored SONG_END lets lower ones through.
        if (STOP) begin
            state_n   = ST_STOPPED;
            presc_n   = '0;
            seconds_n = '0;
        end else if (SONG_END && state == ST_PLAYING) begin
            presc_n   = '0;
            seconds_n = '0;
            chg_n     = 1'b1;
            if (track == TRACK_LAST) begin
                track_n = '0;
                state_n = ST_STOPPED;
            end else begin
                track_n = track + 7'd1;
            end
        end else if (NEXT) begin
            presc_n   = '0;
            seconds_n = '0;
            chg_n     = 1'b1;
            track_n   = (track == TRACK_LAST) ? 7'd0 : track + 7'd1;
        end else if (PREV) begin
            presc_n   = '0;
            seconds_n = '0;
            chg_n     = 1'b1;
            if (seconds < SEC_RESTART)
                track_n = (track == 7'd0) ? TRACK_LAST : track - 7'd1;
        end else if (PLAY_PAUSE) begin
            case (state)
                ST_STOPPED: begin
                    state_n   = ST_PLAYING;
                    presc_n   = '0;
                    seconds_n = '0;
                end
                ST_PLAYING: state_n = ST_PAUSED;
                ST_PAUSED:  state_n = ST_PLAYING;
                default:    state_n = ST_STOPPED;
            endcase
        end

        volume_n = volume;
        if (VOL_UP && !VOL_DN && volume < VOL_TOP)
            volume_n = volume + 7'd1;
        else if (VOL_DN && !VOL_UP && volume != 7'd0)
            volume_n = volume - 7'd1;
    end

    play_status_bin2bcd8 u_track_bcd (
        .bin (track_n + 7'd1),
        .bcd (track_bcd)
    );

    play_status_bin2bcd8 u_volume_bcd (
        .bin (volume_n),
        .bcd (volume_bcd)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_STOPPED;
            presc     <= '0;
            seconds   <= '0;
            track     <= '0;
            volume    <= VOL_RST;
            PLAYING   <= 1'b0;
            TRACK_CHG <= 1'b0;
            DISP      <= {8'h01, VOL_INIT_BCD, 16'd0};
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            seconds   <= seconds_n;
            track     <= track_n;
            volume    <= volume_n;
            PLAYING   <= (state_n == ST_PLAYING);
            TRACK_CHG <= chg_n;
            DISP      <= {track_bcd, volume_bcd, seconds_n};
        end
    end

    assign TRACK  = track;
    assign VOLUME = volume;

endmodule

// File: tb/tb_play_status.sv
// Directed bench for play_status with CLK_HZ=10, TRACKS=8, VOL_MAX=15, VOL_INIT=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_play_status;

    localparam logic [6:0] EV_PP   = 7'h01;
    localparam logic [6:0] EV_STOP = 7'h02;
    localparam logic [6:0] EV_NEXT = 7'h04;
    localparam logic [6:0] EV_PREV = 7'h08;
    localparam logic [6:0] EV_VUP  = 7'h10;
    localparam logic [6:0] EV_VDN  = 7'h20;
    localparam logic [6:0] EV_SEND = 7'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_pause = 1'b0, stop = 1'b0, next = 1'b0, prev = 1'b0;
    logic        vol_up = 1'b0, vol_dn = 1'b0, song_end = 1'b0;
    logic [31:0] disp;
    logic        playing, track_chg;
    logic [6:0]  track, volume;

    int checks = 0;
    int errors = 0;

    play_status #(
        .CLK_HZ   (10),
        .TRACKS   (8),
        .VOL_MAX  (15),
        .VOL_INIT (8)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .PLAY_PAUSE (play_pause),
        .STOP       (stop),
        .NEXT       (next),
        .PREV       (prev),
        .VOL_UP     (vol_up),
        .VOL_DN     (vol_dn),
        .SONG_END   (song_end),
        .DISP       (disp),
        .PLAYING    (playing),
        .TRACK      (track),
        .VOLUME     (volume),
        .TRACK_CHG  (track_chg)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ev);
        {song_end, vol_dn, vol_up, prev, next, stop, play_pause} = ev;
    endtask

    // Called at a falling edge; the event is sampled by exactly one rising edge.
    task automatic pulse(input logic [6:0] ev);
        drive(ev);
        @(negedge clk);
        drive(7'h00);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_disp"},    disp,      32'h0108_0000);
        check({tag, "_playing"}, playing,   1'b0);
        check({tag, "_track"},   track,     7'd0);
        check({tag, "_volume"},  volume,    7'd8);
        check({tag, "_chg"},     track_chg, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        wait_cycles(2);
        check_reset_values("reset");
        rst = 1'b0;

        // Elapsed time: first tick exactly 10 cycles after starting.
        pulse(EV_PP);
        check("start_playing", playing, 1'b1);
        check("start_disp", disp, 32'h0108_0000);
        wait_cycles(9);
        check("before_first_tick", disp[15:0], 16'd0);
        wait_cycles(1);
        check("first_tick", disp[15:0], 16'd1);
        wait_cycles(25);
        check("play35_disp", disp, 32'h0108_0003);
        check("play35_playing", playing, 1'b1);

        // Pause keeps the partial second.
        pulse(EV_STOP);
        check("stop_playing", playing, 1'b0);
        check("stop_secs", disp[15:0], 16'd0);
        pulse(EV_PP);
        wait_cycles(25);
        check("pre_pause_secs", disp[15:0], 16'd2);
        pulse(EV_PP);
        check("paused", playing, 1'b0);
        wait_cycles(100);
        check("no_tick_paused", disp[15:0], 16'd2);
        pulse(EV_PP);
        check("resumed", playing, 1'b1);
        wait_cycles(5);
        check("resume_secs", disp[15:0], 16'd3);

        // Track navigation.
        for (int i = 0; i < 7; i++) pulse(EV_NEXT);
        check("track7", track, 7'd7);
        check("track7_bcd", disp[31:24], 8'h08);
        pulse(EV_NEXT);
        check("next_wrap_track", track, 7'd0);
        check("next_wrap_bcd", disp[31:24], 8'h01);
        check("next_chg", track_chg, 1'b1);
        check("next_secs", disp[15:0], 16'd0);
        check("next_keeps_play", playing, 1'b1);
        wait_cycles(1);
        check("chg_one_cycle", track_chg, 1'b0);
        wait_cycles(9);
        check("secs1", disp[15:0], 16'd1);
        pulse(EV_PREV);
        check("prev_wrap_track", track, 7'd7);
        check("prev_wrap_chg", track_chg, 1'b1);
        wait_cycles(40);
        check("secs4", disp[15:0], 16'd4);
        pulse(EV_PREV);
        check("restart4_track", track, 7'd7);
        check("restart4_secs", disp[15:0], 16'd0);
        check("restart4_chg", track_chg, 1'b1);
        wait_cycles(30);
        check("secs3", disp[15:0], 16'd3);
        pulse(EV_PREV);
        check("restart3_track", track, 7'd7);
        check("restart3_chg", track_chg, 1'b1);

        // SONG_END on the last track stops and wraps; otherwise advances.
        pulse(EV_SEND);
        check("send_last_playing", playing, 1'b0);
        check("send_last_disp", disp, 32'h0108_0000);
        check("send_last_chg", track_chg, 1'b1);
        pulse(EV_NEXT);
        pulse(EV_NEXT);
        pulse(EV_PP);
        check("track2", track, 7'd2);
        pulse(EV_SEND);
        check("send_mid_track", track, 7'd3);
        check("send_mid_playing", playing, 1'b1);
        check("send_mid_bcd", disp[31:24], 8'h04);
        pulse(EV_PP);
        pulse(EV_SEND);
        check("send_paused_track", track, 7'd3);
        check("send_paused_chg", track_chg, 1'b0);

        // STOP outranks NEXT.
        pulse(EV_STOP | EV_NEXT);
        check("stop_next_playing", playing, 1'b0);
        check("stop_next_track", track, 7'd3);
        check("stop_next_chg", track_chg, 1'b0);

        // Volume saturation and cancellation.
        for (int i = 0; i < 10; i++) pulse(EV_VUP);
        check("vol_max", volume, 7'd15);
        check("vol_max_bcd", disp[23:16], 8'h15);
        pulse(EV_VUP | EV_VDN);
        check("vol_cancel", volume, 7'd15);
        pulse(EV_VDN);
        check("vol_dn", disp[23:16], 8'h14);
        for (int i = 0; i < 15; i++) pulse(EV_VDN);
        check("vol_floor", volume, 7'd0);
        check("vol_floor_bcd", disp[23:16], 8'h00);

        // Seconds saturate at 99:59.
        pulse(EV_PP);
        wait_cycles(59980);
        check("secs5998", disp[15:0], 16'd5998);
        wait_cycles(30);
        check("secs_sat", disp, 32'h0400_176F);
        check("sat_playing", playing, 1'b1);

        // Reset overrides same-cycle events.
        rst = 1'b1;
        drive(EV_NEXT | EV_VUP);
        @(negedge clk);
        drive(7'h00);
        check_reset_values("mid_reset");
        rst = 1'b0;
        wait_cycles(1);
        check("post_reset_disp", disp, 32'h0108_0000);
        pulse(EV_PP);
        wait_cycles(10);
        check("post_reset_tick", disp[15:0], 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
